word_deserializer: RTL and testbench
====================================

// Module: word_deserializer
// PURPOSE
//   Serial-to-parallel word gatherer: accepts a stream of WIDTH-bit words over a
//   valid/ready handshake and assembles N consecutive words into one parallel
//   frame, presented with its own valid/ready handshake. Receive-side counterpart
//   of the 4-word state-machine serializer: the first word received lands in
//   out_data[N-1] and the last in out_data[0]. Frames delimited by in_last;
//   length mismatches flagged on out_err.
// PARAMETERS
//   WIDTH  32  bits per word (int-sized)
//   N      4   words per frame; N >= 2
// PORTS
//   clk        in   1          clock; all logic on posedge clk
//   reset      in   1          synchronous, active-high reset
//   in_valid   in   1          input word valid
//   in_ready   out  1          block accepts in_data this cycle
//   in_data    in   WIDTH      input word
//   in_last    in   1          marks final word of frame
//   out_valid  out  1          out_data/out_err hold a complete frame
//   out_ready  in   1          downstream accepts frame
//   out_data   out  N x WIDTH  out_data[N-1-k] = k-th word of frame (k=0 first)
//   out_err    out  1          frame length != N; valid only with out_valid
// BEHAVIOUR
//   - One clock; reset synchronous, active-high. Reset: state COLLECT, count=0,
//     out_valid=0, out_err=0, out_data all zero, drop_pending=0. Reset mid-frame
//     discards partial frame; no output produced for it.
//   - Input accept = in_valid & in_ready; output accept = out_valid & out_ready.
//   - States: COLLECT (in_ready=1, out_valid=0), FULL (in_ready=0, out_valid=1),
//     DROP (in_ready=1, out_valid=0). in_ready/out_valid decoded from state only.
//   - COLLECT, accept with count=k: out_data[N-1-k] <= in_data next cycle.
//     * k<N-1, in_last=0: count <= k+1.
//     * k<N-1, in_last=1: short frame -> FULL, out_err=1; unfilled slots stay 0.
//     * k=N-1, in_last=1: -> FULL, out_err=0.
//     * k=N-1, in_last=0: long frame -> FULL, out_err=1, drop_pending=1.
//   - FULL: out_data/out_err stable until output accept. On accept: count=0,
//     out_data cleared to 0, out_err=0; -> DROP if drop_pending else COLLECT.
//     out_valid falls the cycle after accept.
//   - DROP: words accepted and discarded; accept with in_last=1 -> COLLECT,
//     drop_pending=0.
//   - Latency: out_valid rises the cycle after the frame-ending accept. No input
//     accepted in FULL, so back-to-back frames take >= N+1 cycles each.
//   - out_ready held low: block stalls in FULL indefinitely, in_ready=0, no loss.
//   - count width $clog2(N); never exceeds N-1; no wrap within a frame.
// TESTING
//   1. N=4, words 10,20,30,40 (last on 40), out_ready=1 -> out_data[3:0]=
//      {10,20,30,40}, out_err=0, out_valid 1 cycle after 40 accepted.
//   2. Short frame 7,8 with last on 8 -> out_data={7,8,0,0}, out_err=1; next
//      frame 1,2,3,4 -> {1,2,3,4}, out_err=0 (slots cleared).
//   3. Long frame 1..6, last on 6 -> out_data={1,2,3,4}, out_err=1; 5,6 dropped;
//      next frame 9,9,9,9 -> {9,9,9,9}, out_err=0.
//   4. out_ready=0 for 10 cycles after frame -> out_valid/out_data stable,
//      in_ready=0 throughout; frame delivered once out_ready=1.
//   5. reset=1 after 2 words accepted -> next cycle out_valid=0, count=0; frame
//      5,6,7,8 afterwards -> {5,6,7,8}, out_err=0.
//   6. in_valid toggled randomly, 100 frames -> outputs match reference model.

Source files
------------

// File: rtl/word_deserializer.sv
// word_deserializer: gathers N consecutive WIDTH-bit words into one parallel
// frame. The first word of a frame lands in out_data[N-1] and the last in
// out_data[0]. in_last ends a frame. A frame with any length other than N is
// flagged on out_err. The words after the N-th word of a long frame are dropped.
//
// Handshake: a word moves on a cycle where in_valid & in_ready, and a frame
// moves on a cycle where out_valid & out_ready. A source holding valid must keep
// its payload stable until that cycle. in_ready and out_valid depend on the FSM
// state only, so they never depend combinationally on in_valid or out_ready.
module word_deserializer #(
    parameter int WIDTH = 32,
    parameter int N     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N-1:0][WIDTH-1:0]   out_data,
    output logic                      out_err
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FULL    = 2'd1,
        DROP    = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;
    logic          drop_pending;
    logic          in_accept;
    logic          out_accept;
    logic          at_last_slot;

    assign in_accept    = in_valid & in_ready;
    assign out_accept   = out_valid & out_ready;
    assign at_last_slot = (count == LAST_IDX);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A frame ends on in_last or when the N-th word arrives.
    always_comb begin
        state_next = state;
        case (state)
            COLLECT: begin
                if (in_accept && (in_last || at_last_slot)) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (out_accept) begin
                    state_next = drop_pending ? DROP : COLLECT;
                end
            end
            DROP: begin
                if (in_accept && in_last) begin
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    // Handshake outputs are decoded from the state only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            COLLECT: in_ready  = 1'b1;
            FULL:    out_valid = 1'b1;
            DROP:    in_ready  = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Datapath: slot fill, word count, error flag and long-frame drop marker.
    always_ff @(posedge clk) begin
        if (reset) begin
            count        <= '0;
            out_data     <= '0;
            out_err      <= 1'b0;
            drop_pending <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (in_accept) begin
                        out_data[LAST_IDX - count] <= in_data;
                        if (at_last_slot) begin
                            // N words are in. Without in_last the frame is too long.
                            out_err      <= ~in_last;
                            drop_pending <= ~in_last;
                        end else if (in_last) begin
                            // Short frame. The unfilled slots keep their cleared zeros.
                            out_err <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (out_accept) begin
                        count    <= '0;
                        out_data <= '0;
                        out_err  <= 1'b0;
                    end
                end
                DROP: begin
                    if (in_accept && in_last) begin
                        drop_pending <= 1'b0;
                    end
                end
                default: begin
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_word_deserializer.sv
// Bench for word_deserializer. A frame-level model predicts the handshake and
// the frame contents on every cycle. Directed tests pin frames to literals.
module tb_word_deserializer;

    localparam int W = 32;
    localparam int N = 4;
    localparam int FW = N * W + 1;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [W-1:0]          in_data = '0;
    logic                  in_last = 1'b0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [N-1:0][W-1:0]   out_data;
    logic                  out_err;

    int checks = 0;
    int failures = 0;

    word_deserializer #(.WIDTH(W), .N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // out_ready is driven from one place: random when rand_ready, else ready_cmd.
    logic rand_ready = 1'b0;
    logic ready_cmd  = 1'b1;
    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_cmd;
    end

    task automatic check(input string name, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    // The model collects words into a list. A frame closes on in_last or on the
    // N-th word. While a frame waits for delivery, nothing is accepted. After a
    // long frame is delivered, words are discarded up to and including in_last.
    logic [W-1:0]        m_words[$];
    logic                m_hold = 1'b0;
    logic                m_drop = 1'b0;
    logic                m_long = 1'b0;
    logic [N-1:0][W-1:0] m_frame = '0;
    logic                m_err = 1'b0;
    logic                started = 1'b0;
    logic [FW-1:0]       exp_q[$];

    always @(posedge clk) begin
        started = 1'b1;
        if (reset) begin
            m_words.delete();
            exp_q.delete();
            m_hold = 1'b0;
            m_drop = 1'b0;
            m_long = 1'b0;
        end else if (m_hold) begin
            if (out_ready) begin
                m_hold = 1'b0;
                m_drop = m_long;
            end
        end else if (in_valid) begin
            if (m_drop) begin
                if (in_last) m_drop = 1'b0;
            end else begin
                m_words.push_back(in_data);
                if (in_last || m_words.size() == N) begin
                    m_frame = '0;
                    for (int k = 0; k < m_words.size(); k++) m_frame[N-1-k] = m_words[k];
                    m_long = (m_words.size() == N) && !in_last;
                    m_err  = (m_words.size() != N) || !in_last;
                    m_hold = 1'b1;
                    exp_q.push_back({m_err, m_frame});
                    m_words.delete();
                end
            end
        end
    end

    // ---------------- per-cycle compare and delivery scoreboard ----------------
    logic [N-1:0][W-1:0] got_frame = '0;
    logic                got_err = 1'b0;
    int                  delivered = 0;

    always @(negedge clk) begin
        if (started) begin
            check("in_ready", FW'(in_ready), FW'(!m_hold));
            check("out_valid", FW'(out_valid), FW'(m_hold));
            if (m_hold) begin
                check("out_frame", {out_err, out_data}, {m_err, m_frame});
            end
            if (out_valid && out_ready && !reset) begin
                got_frame = out_data;
                got_err   = out_err;
                delivered++;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", {out_err, out_data}, '0);
                end else begin
                    check("delivered_frame", {out_err, out_data}, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_word(input logic [W-1:0] w, input logic last);
        int budget = 0;
        in_valid = 1'b1;
        in_data  = w;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) check("in_ready_timeout", FW'(in_ready), FW'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_delivery(input int start);
        int budget = 0;
        while (delivered == start && budget < 200) begin
            @(posedge clk);
            budget++;
        end
        #1;
        check("delivery_timeout", FW'(delivered - start), FW'(1));
    endtask

    task automatic chk_frame(input string name, input logic [N-1:0][W-1:0] ef, input logic ee);
        check(name, {got_err, got_frame}, {ee, ef});
    endtask

    // ---------------- directed and random stimulus ----------------
    initial begin
        int start;
        int len;
        logic [N-1:0][W-1:0] lit;

        idle(2);
        reset = 1'b0;
        @(negedge clk);
        check("reset_out_valid", FW'(out_valid), FW'(0));
        check("reset_in_ready", FW'(in_ready), FW'(1));
        check("reset_out_data", {out_err, out_data}, '0);
        @(posedge clk);
        #1;

        // 1: exact frame. out_valid is high right after the accept of 40.
        start = delivered;
        send_word(32'd10, 1'b0);
        send_word(32'd20, 1'b0);
        send_word(32'd30, 1'b0);
        send_word(32'd40, 1'b1);
        check("t1_latency", FW'(out_valid), FW'(1));
        wait_delivery(start);
        lit = {32'd10, 32'd20, 32'd30, 32'd40};
        chk_frame("t1_frame", lit, 1'b0);

        // 2: short frame, then a full frame that sees the slots cleared.
        start = delivered;
        send_word(32'd7, 1'b0);
        send_word(32'd8, 1'b1);
        wait_delivery(start);
        lit = {32'd7, 32'd8, 32'd0, 32'd0};
        chk_frame("t2_short", lit, 1'b1);
        start = delivered;
        for (int i = 1; i <= 4; i++) send_word(W'(i), i == 4);
        wait_delivery(start);
        lit = {32'd1, 32'd2, 32'd3, 32'd4};
        chk_frame("t2_after", lit, 1'b0);

        // 3: long frame 1..6. Words 5 and 6 are dropped.
        start = delivered;
        for (int i = 1; i <= 6; i++) send_word(W'(i), i == 6);
        check("t3_count", FW'(delivered - start), FW'(1));
        lit = {32'd1, 32'd2, 32'd3, 32'd4};
        chk_frame("t3_long", lit, 1'b1);
        start = delivered;
        for (int i = 0; i < 4; i++) send_word(32'd9, i == 3);
        wait_delivery(start);
        lit = {32'd9, 32'd9, 32'd9, 32'd9};
        chk_frame("t3_after", lit, 1'b0);

        // 4: downstream stall for 10 cycles.
        ready_cmd = 1'b0;
        idle(1);
        start = delivered;
        for (int i = 0; i < 4; i++) send_word(W'(21 + i), i == 3);
        lit = {32'd21, 32'd22, 32'd23, 32'd24};
        repeat (10) begin
            @(negedge clk);
            check("t4_valid", FW'(out_valid), FW'(1));
            check("t4_in_ready", FW'(in_ready), FW'(0));
            check("t4_data", {out_err, out_data}, {1'b0, lit});
        end
        ready_cmd = 1'b1;
        wait_delivery(start);
        chk_frame("t4_frame", lit, 1'b0);

        // 5: reset after two words discards the partial frame.
        send_word(32'd11, 1'b0);
        send_word(32'd12, 1'b0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        @(negedge clk);
        check("t5_out_valid", FW'(out_valid), FW'(0));
        check("t5_in_ready", FW'(in_ready), FW'(1));
        @(posedge clk);
        #1;
        start = delivered;
        for (int i = 5; i <= 8; i++) send_word(W'(i), i == 8);
        wait_delivery(start);
        lit = {32'd5, 32'd6, 32'd7, 32'd8};
        chk_frame("t5_frame", lit, 1'b0);

        // 6: 100 random frames of 1..N+2 words, with random gaps and stalls.
        start = delivered;
        rand_ready = 1'b1;
        for (int f = 0; f < 100; f++) begin
            len = $urandom_range(1, N + 2);
            for (int i = 0; i < len; i++) begin
                idle($urandom_range(0, 2));
                send_word(W'($urandom), i == len - 1);
            end
        end
        rand_ready = 1'b0;
        ready_cmd  = 1'b1;
        idle(6);
        check("t6_frames", FW'(delivered - start), FW'(100));
        check("t6_drained", FW'(exp_q.size()), FW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
